// File: rtl/mem_read_sequencer.sv
// Memory read sequencer: takes a one-shot read request from the control unit,
// runs a request/acknowledge handshake to memory, captures the returned word
// into a held register and reports completion or timeout.
//
// Handshake: the control side requests with rd_start, which is sampled only
// while rd_busy is low. A request seen while rd_busy is high is dropped, not
// queued. Towards memory, mem_en is the request. It stays high, with mem_addr
// stable, until memory answers with mem_ack or the wait budget runs out.
// mem_rdata is consumed only on an edge where mem_en and mem_ack are both high.
module mem_read_sequencer #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 8
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              rd_start,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_busy,
    output logic              rd_done,
    output logic              rd_error,
    output logic [DATA_W-1:0] rd_data,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [1:0]        dbg_state
);

    // Wide enough to hold TIMEOUT; a TIMEOUT of 1 still gets a 1-bit counter.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] wait_cnt;

    // Sequencer state, wait counter and the held address/data/error registers.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
            mem_addr <= '0;
            rd_data  <= '0;
            rd_error <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rd_start) begin
                        mem_addr <= rd_addr;
                        rd_error <= 1'b0;
                        wait_cnt <= '0;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // An ack on the final budgeted edge still counts as success.
                    if (mem_ack) begin
                        rd_data <= mem_rdata;
                        state   <= ST_DONE;
                    end else if (wait_cnt == CNT_LAST) begin
                        rd_error <= 1'b1;
                        state    <= ST_DONE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Status and memory request are decoded from state alone, so no input
    // reaches an output without passing through a register.
    always_comb begin
        mem_en    = (state == ST_WAIT);
        rd_busy   = (state == ST_WAIT) || (state == ST_DONE);
        rd_done   = (state == ST_DONE);
        dbg_state = state;
    end

endmodule

// File: tb/tb_mem_read_sequencer.sv
// Testbench for mem_read_sequencer: directed scenarios plus randomized reads,
// checked against a transaction-level model of the read protocol.
module tb_mem_read_sequencer;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 8;

  // ---------------- clock / reset ----------------
  logic              CLK = 1'b0;
  logic              Reset;
  logic              rd_start;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_busy;
  logic              rd_done;
  logic              rd_error;
  logic [DATA_W-1:0] rd_data;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;
  logic [1:0]        dbg_state;

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc++;

  mem_read_sequencer #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .CLK(CLK), .Reset(Reset), .rd_start(rd_start), .rd_addr(rd_addr),
    .rd_busy(rd_busy), .rd_done(rd_done), .rd_error(rd_error),
    .rd_data(rd_data), .mem_en(mem_en), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard / model ----------------
  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] model_data;
  logic              model_error;
  int last_done_cyc = -1;
  int done_gap      = 0;

  // ---------------- driver tasks ----------------
  // Called just after a negedge with the DUT idle. ack_edge = WAIT edge on which
  // memory answers (0 or > TIMEOUT means it never answers during WAIT).
  task automatic do_read(input logic [ADDR_W-1:0] addr, input int ack_edge,
                         input logic [DATA_W-1:0] rdata, input bit poke, input int trail);
    bit ok;
    int k, last, en_cnt, busy_cnt, done_cnt, done_at;
    logic [DATA_W-1:0] exp_d;
    ok = (ack_edge >= 1) && (ack_edge <= TIMEOUT);
    k = ok ? ack_edge : TIMEOUT;
    if (ok) model_data = rdata;
    model_error = !ok;
    exp_q.push_back(model_data);
    en_cnt = 0; busy_cnt = 0; done_cnt = 0; done_at = -1;
    last = k + 1 + trail;
    rd_start = 1'b1; rd_addr = addr; mem_ack = 1'b0; mem_rdata = DATA_W'($urandom);
    for (int c = 1; c <= last; c++) begin
      @(negedge CLK);
      rd_start = 1'b0;
      if (mem_en) begin
        en_cnt++;
        checks++;
        if (mem_addr !== addr) begin
          errors++;
          $display("FAIL mem_addr cycle %0d: got %h expected %h", c, mem_addr, addr);
        end
      end
      if (rd_busy) busy_cnt++;
      if (c == 1) begin
        checks++;
        if (rd_error !== 1'b0) begin
          errors++;
          $display("FAIL rd_error_cleared_on_start: got %b expected 0", rd_error);
        end
      end
      if (rd_done) begin
        done_cnt++;
        done_at = c;
        if (last_done_cyc >= 0) done_gap = cyc - last_done_cyc;
        last_done_cyc = cyc;
        exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : model_data;
        checks++;
        if (rd_data !== exp_d) begin
          errors++;
          $display("FAIL rd_data_at_done: got %h expected %h", rd_data, exp_d);
        end
      end
      mem_ack = (c == ack_edge);
      mem_rdata = mem_ack ? rdata : DATA_W'($urandom);
      if (poke && c == k + 1) begin
        mem_ack = 1'b1;
        mem_rdata = ~rdata;
      end
      if (poke && (c == 2 || c == k + 1)) begin
        rd_start = 1'b1;
        rd_addr = 16'hFFFF;
      end
    end
    mem_ack = 1'b0;
    checks++;
    if (en_cnt != k) begin
      errors++;
      $display("FAIL mem_en_cycles: got %0d expected %0d", en_cnt, k);
    end
    checks++;
    if (busy_cnt != k + 1) begin
      errors++;
      $display("FAIL rd_busy_cycles: got %0d expected %0d", busy_cnt, k + 1);
    end
    checks++;
    if (done_cnt != 1 || done_at != k + 1) begin
      errors++;
      $display("FAIL rd_done_pulse: got count %0d at cycle %0d expected 1 at %0d",
               done_cnt, done_at, k + 1);
    end
    checks++;
    if (rd_error !== model_error) begin
      errors++;
      $display("FAIL rd_error_after: got %b expected %b", rd_error, model_error);
    end
    checks++;
    if (rd_data !== model_data) begin
      errors++;
      $display("FAIL rd_data_after: got %h expected %h", rd_data, model_data);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    Reset = 1'b1; rd_start = 1'b0; rd_addr = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge CLK);
    model_data = '0; model_error = 1'b0;
    checks++;
    if ({rd_busy, rd_done, rd_error, mem_en} !== 4'b0000 || rd_data !== '0 || mem_addr !== '0) begin
      errors++;
      $display("FAIL reset_values: got busy=%b done=%b err=%b en=%b data=%h addr=%h expected all 0",
               rd_busy, rd_done, rd_error, mem_en, rd_data, mem_addr);
    end
    // Reset and a request together: reset wins, request dropped.
    rd_start = 1'b1; rd_addr = 16'h0ABC;
    @(negedge CLK);
    Reset = 1'b0; rd_start = 1'b0;
    @(negedge CLK);
    checks++;
    if (rd_busy !== 1'b0 || mem_en !== 1'b0 || mem_addr !== '0) begin
      errors++;
      $display("FAIL reset_with_start: got busy=%b en=%b addr=%h expected 0 0 0000",
               rd_busy, mem_en, mem_addr);
    end
  endtask

  task automatic test_zero_wait();
    do_read(16'h0040, 1, 16'hBEEF, 1'b0, 1);
  endtask

  task automatic test_wait_states();
    do_read(16'h1234, 4, 16'h00A5, 1'b0, 1);
  endtask

  task automatic test_timeout();
    do_read(16'h2000, 0, 16'h1111, 1'b0, 1);
  endtask

  task automatic test_ack_on_last_edge_and_busy_request();
    do_read(16'h3000, TIMEOUT, 16'h7E7E, 1'b1, 3);
  endtask

  task automatic test_reset_mid_wait();
    rd_start = 1'b1; rd_addr = 16'h4444; mem_ack = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge CLK);
      rd_start = 1'b0;
      if (c == 3) begin
        model_data = '0; model_error = 1'b0;
        checks++;
        if (mem_en !== 1'b0 || rd_busy !== 1'b0 || rd_data !== '0) begin
          errors++;
          $display("FAIL reset_mid_wait: got en=%b busy=%b data=%h expected 0 0 0000",
                   mem_en, rd_busy, rd_data);
        end
      end
      if (c >= 3) begin
        checks++;
        if (rd_done !== 1'b0) begin
          errors++;
          $display("FAIL reset_no_done cycle %0d: got %b expected 0", c, rd_done);
        end
      end
      Reset = (c == 2);
    end
  endtask

  task automatic test_stray_ack();
    mem_ack = 1'b1; mem_rdata = 16'h5555;
    for (int c = 1; c <= 4; c++) begin
      @(negedge CLK);
      checks++;
      if (rd_data !== model_data || rd_done !== 1'b0 || mem_en !== 1'b0) begin
        errors++;
        $display("FAIL stray_ack: got data=%h done=%b en=%b expected data=%h done=0 en=0",
                 rd_data, rd_done, mem_en, model_data);
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    last_done_cyc = -1;
    for (int i = 0; i < 3; i++) begin
      do_read(ADDR_W'($urandom), 1, DATA_W'($urandom), 1'b0, 1);
      if (i > 0) begin
        checks++;
        if (done_gap != 3) begin
          errors++;
          $display("FAIL done_spacing: got %0d expected 3", done_gap);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      do_read(ADDR_W'($urandom_range(0, 16'hFFFE)), $urandom_range(0, TIMEOUT + 2),
              DATA_W'($urandom), bit'($urandom_range(0, 1)), $urandom_range(1, 3));
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_timeout();
    test_ack_on_last_edge_and_busy_request();
    test_reset_mid_wait();
    test_stray_ack();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_read_sequencer.md
Name: mem_read_sequencer

Overview:
- Read-side counterpart to the datapath's clocked capture registers. It accepts a one-shot read request from the multi-cycle control unit and drives a request/acknowledge handshake to instruction/data memory.
- Captures the returned word into a held output register and reports done or timeout to the control FSM.
- Sits between the control unit / MDR path and the memory block.

Parameters:
- DATA_W, 16, width of the data word.
- ADDR_W, 16, width of the address.
- TIMEOUT, 8, maximum number of WAIT-state clock edges without mem_ack before the read is aborted. Legal range is 1 or more.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- rd_start  in  1  read request; sampled only in IDLE.
- rd_addr  in  ADDR_W  read address; sampled together with rd_start.
- rd_busy  out  1  high in WAIT and DONE.
- rd_done  out  1  one-cycle pulse when a read finishes (success or timeout).
- rd_error  out  1  high when the last read timed out.
- rd_data  out  DATA_W  last successfully read word, held stable.
- mem_en  out  1  memory read request, held for the whole handshake.
- mem_addr  out  ADDR_W  latched address, stable while mem_en is high.
- mem_rdata  in  DATA_W  memory read data; valid when mem_ack is high.
- mem_ack  in  1  memory acknowledge.

Behaviour:
- Clock and reset: one clock, CLK. Reset is synchronous and active-high.
- Reset values (applied on the first rising edge with Reset high):
  - state = IDLE
  - rd_busy = 0, rd_done = 0, rd_error = 0
  - rd_data = 0
  - mem_en = 0, mem_addr = 0
  - wait counter = 0
- Counter width: ceil(log2(TIMEOUT+1)) bits.
- All outputs are registered or decoded from state only. There is no combinational path from input to output.
- IDLE:
  - If rd_start is 1 at the edge: latch rd_addr into mem_addr, clear rd_error, clear the counter, go to WAIT.
  - Otherwise stay in IDLE.
  - mem_en = 0, rd_busy = 0.
- WAIT:
  - mem_en = 1, rd_busy = 1. mem_addr holds its value.
  - At each edge:
    - If mem_ack = 1: rd_data <= mem_rdata, go to DONE.
    - Else if counter == TIMEOUT-1: rd_error <= 1, rd_data unchanged, go to DONE.
    - Else counter + 1.
- DONE:
  - rd_done = 1, mem_en = 0, rd_busy = 1.
  - Unconditionally go to IDLE on the next edge.
- Latency:
  - rd_start accepted at edge N, mem_ack high at the first WAIT edge (N+1): rd_done is high during the cycle after edge N+1.
  - General case, ack at the k-th WAIT edge: rd_done follows edge N+k.
  - Timeout: rd_done follows edge N+TIMEOUT.
- Boundary conditions:
  - rd_start while rd_busy = 1 (WAIT or DONE) is ignored. It is not queued.
  - Next possible accept is the edge after DONE, so the minimum spacing between rd_done pulses is 3 cycles.
  - mem_ack in IDLE or DONE is ignored. rd_data does not change.
  - mem_ack on the same edge the counter reaches TIMEOUT-1: ack wins, rd_error stays 0, data is captured.
  - rd_error is sticky until the next accepted rd_start.
  - rd_data changes only on a successful capture or on reset.
- Reset mid-operation (WAIT or DONE): on the next edge the block returns to IDLE with reset values. No rd_done pulse is generated and mem_en drops immediately after that edge.
- Reset and rd_start in the same cycle: reset wins and the request is dropped.

Test Plan:
1. Zero-wait read: Reset, then rd_start=1 with rd_addr=16'h0040, and mem_ack=1 with mem_rdata=16'hBEEF in the first WAIT cycle. Required: mem_en high for exactly 1 cycle with mem_addr=16'h0040; rd_done pulses 1 cycle later; rd_data=16'hBEEF; rd_error=0.
2. Wait states: rd_addr=16'h1234, mem_ack asserted at the 4th WAIT edge with mem_rdata=16'h00A5. Required: mem_en high for 4 cycles with mem_addr stable; rd_done 1 cycle; rd_data=16'h00A5; rd_busy high for 5 cycles.
3. Timeout: TIMEOUT=8, mem_ack never asserted. Required: mem_en high for 8 cycles; rd_done pulse; rd_error=1; rd_data keeps its prior value 16'h00A5. A new rd_start clears rd_error.
4. Ack on the timeout edge, then a request while busy: mem_ack=1 at WAIT edge 8 with mem_rdata=16'h7E7E, and rd_start pulsed with rd_addr=16'hFFFF during WAIT. Required: rd_error=0; rd_data=16'h7E7E; mem_addr never shows 16'hFFFF; no second read occurs.
5. Reset mid-WAIT: Reset asserted at the 2nd WAIT cycle. Required: next cycle mem_en=0, rd_busy=0, rd_data=0; no rd_done pulse.
6. Stray ack: mem_ack=1 with mem_rdata=16'h5555 while in IDLE. Required: rd_data unchanged and rd_done stays 0.
